fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the write port of the async FIFO (valid_input / from_user) among NUM_REQ producers in the w_clk domain.
- Grants requesters round-robin with bounded bursts and stalls on FIFO full/almost_full.
- Drives registered, glitch-free write strobes into the FIFO top.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_W, 8, data width; matches FIFO word width.
- MAX_BURST, 4, maximum accepted beats per grant before forced rotation (1..15).

Ports:
- w_clk  in  1  write-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- fifo_full  in  1  FIFO full flag, w_clk domain.
- fifo_almost_full  in  1  FIFO almost-full flag; asserts with at least 1 free slot remaining.
- valid_input  out  1  FIFO write strobe, registered.
- from_user  out  DATA_W  FIFO write data, registered.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, valid_input=0, from_user=0, grant_id=0, busy=0, req_ready=0.
  - rr_ptr=0, beat_cnt=0.
- Release of rst_n is used synchronously on w_clk.
- Handshake:
  - Beat accepted on a w_clk rising edge when req_valid[g] && req_ready[g].
  - req_ready[g] = (state==GRANT) && (grant_id==g) && !fifo_full && !fifo_almost_full. This is combinational from registered state and the FIFO flags.
- Latency: accepted beat appears on valid_input/from_user exactly 1 cycle later. valid_input is low in every cycle without a preceding accept.
- Data capture: from_user holds its last value when valid_input=0.
- FSM states: IDLE, GRANT, HOLD.
  - IDLE: if any req_valid, pick the first set bit scanning from rr_ptr upward (wrapping modulo NUM_REQ). Load grant_id, clear beat_cnt, go to GRANT next cycle. No accept occurs in IDLE.
  - GRANT, flag stall: fifo_full or fifo_almost_full go to HOLD with no accept.
  - GRANT, accept: beat_cnt++. If beat_cnt reaches MAX_BURST, release.
  - GRANT, no valid: if req_valid[grant_id]=0 (no accept), release.
  - HOLD: stay while fifo_full || fifo_almost_full; both low returns to GRANT with beat_cnt preserved. Requester dropping valid during HOLD releases.
- Release: rr_ptr = grant_id+1 mod NUM_REQ. If any req_valid is present, arbitrate immediately in the same cycle and re-enter GRANT with the new grant_id, so there are no idle bubbles between grants. Otherwise go to IDLE.
- Fairness: a continuously valid requester waits at most (NUM_REQ-1)*(MAX_BURST+1) accept-capable cycles.
- Simultaneous events:
  - Flag rising in the same cycle as a valid beat: no accept (ready already low), go to HOLD.
  - Last-burst beat coincident with other requests: rotation occurs and the next grant starts the following cycle.
- Overflow guarantee: the FIFO is never written when fifo_full=1 at the accept edge. The in-flight registered beat relies on the almost_full margin of at least 1.
- beat_cnt width: clog2(MAX_BURST+1). rr_ptr wraps at NUM_REQ-1 to 0; non-power-of-2 NUM_REQ must be handled.
- Mid-operation reset: an in-flight valid_input is dropped immediately and no write is issued after assertion.

Decomposition:
- Shared package fifo_pkg:
  - DATA_W default.
  - FSM state encoding localparams ST_IDLE=2'd0, ST_GRANT=2'd1, ST_HOLD=2'd2.
  - clog2 helper function.
- One sub-module rr_picker: combinational round-robin priority select.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, idx.
  - Instantiated once, reused in IDLE and at release.

Test Plan:
- Single requester: rst_n low for 13 ns, then req_valid=4'b0001 with data 8'h11..8'h16 → grants of 4 beats then 2 beats (re-granted to req 0 after release). valid_input follows each accept by 1 cycle; from_user sequence is 11,12,13,14,15,16.
- All four valid continuously, MAX_BURST=4 → grant_id order 0,1,2,3,0. Exactly 4 beats each, no idle cycle between bursts, req_ready one-hot.
- fifo_almost_full forced high for 5 cycles mid-burst of req 2 after 2 beats → HOLD, req_ready=0, valid_input=0 (after the in-flight beat). Resumes and completes the remaining 2 beats with grant_id=2.
- fifo_full and req_valid rising on the same edge → no accept, no valid_input pulse, state HOLD.
- Requester 1 drops valid after 1 beat while req 3 is pending → release; next grant_id=3 (rr_ptr=2 scan skips 2), not 0.
- Assert rst_n low mid-burst with valid_input=1 → valid_input, busy, req_ready all 0 immediately. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
//   FIFO_DATA_W : default FIFO word width
//   state_t     : arbiter FSM encoding
//   clog2       : ceiling log2 used for index and counter widths
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin priority select.
//   req_i   : request vector (N bits)
//   ptr_i   : highest-priority index for this scan
//   found_o : at least one request is set
//   idx_o   : first set request at or above ptr_i, wrapping modulo N
module rr_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    int unsigned c;
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (32'(ptr_i) + k) % N;
      if (!found_o && req_i[c]) begin
        found_o = 1'b1;
        idx_o   = W'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// producers in the w_clk domain, with bounded bursts and flag stalls.
//   w_clk, rst_n       : write clock, asynchronous active-low reset
//   req_valid/req_data : producer beats (requester i at [i*DATA_W +: DATA_W])
//   req_ready          : one-hot (or zero) accept to the granted producer
//   fifo_full/almost   : FIFO write-side flags
//   valid_input        : registered FIFO write strobe
//   from_user          : registered FIFO write data
//   grant_id           : current or last granted requester
//   busy               : FSM not idle
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = FIFO_DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      w_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_almost_full,
  output logic                      valid_input,
  output logic [DATA_W-1:0]         from_user,
  output logic [clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned BC_W  = clog2(MAX_BURST + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]    beat_q, beat_d;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;

  logic               stall;
  logic               sel_valid;
  logic               accept;
  logic [DATA_W-1:0]  sel_data;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [BC_W-1:0]    beat_inc;
  logic               release_g;

  assign stall     = fifo_full | fifo_almost_full;
  assign sel_valid = req_valid[grant_q];
  assign accept    = (state_q == ST_GRANT) && !stall && sel_valid;
  assign next_ptr  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
  assign beat_inc  = beat_q + BC_W'(1);

  // One picker serves both idle arbitration (from rr_ptr) and release
  // re-arbitration (from grant+1, the pointer being loaded that cycle).
  assign pick_ptr = (state_q == ST_IDLE) ? rr_ptr_q : next_ptr;

  rr_picker #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    beat_d    = beat_q;
    release_g = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (stall) begin
          state_d = ST_HOLD;
        end else if (sel_valid) begin
          if (beat_inc == BC_W'(MAX_BURST)) release_g = 1'b1;
          else                              beat_d    = beat_inc;
        end else begin
          release_g = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!sel_valid)  release_g = 1'b1;
        else if (!stall) state_d   = ST_GRANT;
      end
      default: state_d = ST_IDLE;
    endcase

    // Release re-arbitrates in the same cycle so back-to-back grants
    // carry no idle bubble.
    if (release_g) begin
      rr_ptr_d = next_ptr;
      beat_d   = '0;
      if (pick_found) begin
        grant_d = pick_idx;
        state_d = ST_GRANT;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (state_q == ST_GRANT && !stall) req_ready[grant_q] = 1'b1;
    busy     = (state_q != ST_IDLE);
    grant_id = grant_q;
  end

  // Write strobe and data, one cycle behind the accept
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= accept;
      if (accept) data_q <= sel_data;
    end
  end

  assign valid_input = valid_q;
  assign from_user   = data_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  logic        w_clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic        valid_input;
  logic [7:0]  from_user;
  logic [1:0]  grant_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fifo_write_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .MAX_BURST (4)
  ) dut (
    .w_clk            (w_clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .valid_input      (valid_input),
    .from_user        (from_user),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        full;
    logic        afull;
    logic [3:0]  e_rdy;
    logic        e_vi;
    logic [7:0]  e_fu;
    logic [1:0]  e_gid;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D = 32'h43424140;

  task automatic row(input logic r, input logic [3:0] v, input logic [31:0] d,
                     input logic f, input logic af, input logic [3:0] er,
                     input logic evi, input logic [7:0] efu, input logic [1:0] eg,
                     input logic eb);
    vec_t x;
    x.rst = r; x.vld = v; x.dat = d; x.full = f; x.afull = af;
    x.e_rdy = er; x.e_vi = evi; x.e_fu = efu; x.e_gid = eg; x.e_busy = eb;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t x);
    logic [15:0] got, exp;
    got = {req_ready, valid_input, from_user, grant_id, busy};
    exp = {x.e_rdy, x.e_vi, x.e_fu, x.e_gid, x.e_busy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d got rdy=%b vi=%b fu=%h gid=%0d busy=%b exp rdy=%b vi=%b fu=%h gid=%0d busy=%b",
               i, req_ready, valid_input, from_user, grant_id, busy,
               x.e_rdy, x.e_vi, x.e_fu, x.e_gid, x.e_busy);
    end
    chk($sformatf("onehot%0d", i), 32'($countones(req_ready) <= 1), 32'd1);
  endtask

  initial begin
    int g, pg;
    bit seen;

    // Single requester: 4-beat burst, re-grant to req 0, then 2 beats
    row(1, 4'b0001, 32'h11, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b0001, 32'h11, 0, 0, 4'b0001, 0, 8'h00, 0, 1);
    row(1, 4'b0001, 32'h12, 0, 0, 4'b0001, 1, 8'h11, 0, 1);
    row(1, 4'b0001, 32'h13, 0, 0, 4'b0001, 1, 8'h12, 0, 1);
    row(1, 4'b0001, 32'h14, 0, 0, 4'b0001, 1, 8'h13, 0, 1);
    row(1, 4'b0001, 32'h15, 0, 0, 4'b0001, 1, 8'h14, 0, 1);
    row(1, 4'b0001, 32'h16, 0, 0, 4'b0001, 1, 8'h15, 0, 1);
    row(1, 4'b0000, 32'h16, 0, 0, 4'b0001, 1, 8'h16, 0, 1);
    row(1, 4'b0000, 32'h16, 0, 0, 4'b0000, 0, 8'h16, 0, 0);

    // All four valid: bursts of 4 in order 0,1,2,3,0 with no gap
    row(0, 4'b1111, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b1111, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      g  = ((k - 1) / 4) % 4;
      pg = ((k - 2) / 4) % 4;
      row(1, 4'b1111, D, 0, 0, 4'(1 << g), (k >= 2), (k >= 2) ? 8'(8'h40 + pg) : 8'h00, 2'(g), 1);
    end

    // almost_full for 5 cycles after 2 beats of req 2
    row(0, 4'b0100, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b0100, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 0, 8'h00, 2, 1);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 1, 8'h42, 2, 1);
    row(1, 4'b0100, D, 0, 1, 4'b0000, 1, 8'h42, 2, 1);
    for (int k = 0; k < 4; k++) row(1, 4'b0100, D, 0, 1, 4'b0000, 0, 8'h42, 2, 1);
    row(1, 4'b0100, D, 0, 0, 4'b0000, 0, 8'h42, 2, 1);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 0, 8'h42, 2, 1);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 1, 8'h42, 2, 1);
    row(1, 4'b0000, D, 0, 0, 4'b0100, 1, 8'h42, 2, 1);
    row(1, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h42, 2, 0);

    // fifo_full rising with req_valid: no accept, HOLD until full drops
    row(0, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b0001, D, 1, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b0001, D, 1, 0, 4'b0000, 0, 8'h00, 0, 1);
    row(1, 4'b0001, D, 1, 0, 4'b0000, 0, 8'h00, 0, 1);
    row(1, 4'b0001, D, 0, 0, 4'b0000, 0, 8'h00, 0, 1);
    row(1, 4'b0001, D, 0, 0, 4'b0001, 0, 8'h00, 0, 1);
    row(1, 4'b0000, D, 0, 0, 4'b0001, 1, 8'h40, 0, 1);
    row(1, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h40, 0, 0);

    // req 1 drops after one beat; scan from 2 picks 3 over 0
    row(0, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b1010, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b1010, D, 0, 0, 4'b0010, 0, 8'h00, 1, 1);
    row(1, 4'b1001, D, 0, 0, 4'b0010, 1, 8'h41, 1, 1);
    row(1, 4'b1001, D, 0, 0, 4'b1000, 0, 8'h41, 3, 1);
    row(1, 4'b0001, D, 0, 0, 4'b1000, 1, 8'h43, 3, 1);
    row(1, 4'b0000, D, 0, 0, 4'b0001, 0, 8'h43, 0, 1);
    row(1, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h43, 0, 0);

    // Reset mid-burst after a rotation; arbitration restarts at 0
    row(0, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b0100, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 0, 8'h00, 2, 1);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 1, 8'h42, 2, 1);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 1, 8'h42, 2, 1);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 1, 8'h42, 2, 1);
    row(1, 4'b0100, D, 0, 0, 4'b0100, 1, 8'h42, 2, 1);
    row(0, 4'b1111, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b1111, D, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
    row(1, 4'b1111, D, 0, 0, 4'b0001, 0, 8'h00, 0, 1);

    rst_n = 1'b0; req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    #10;
    chk("reset_state", {req_ready, valid_input, from_user, grant_id, busy}, '0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge w_clk);
      #1;
      rst_n = vecs[i].rst; req_valid = vecs[i].vld; req_data = vecs[i].dat;
      fifo_full = vecs[i].full; fifo_almost_full = vecs[i].afull;
      #4;
      chk_vec(i, vecs[i]);
    end

    // Asynchronous reset between edges while a write strobe is high
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge w_clk);
      if (valid_input) seen = 1;
    end
    chk("vi_wait", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {req_ready, valid_input, grant_id, busy}, '0);
    @(posedge w_clk);
    #1 rst_n = 1'b1; req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge w_clk);
      chk($sformatf("no_write%0d", k), {valid_input, busy}, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
